reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Owns the single write port of the 8x8 register file. Arbitrates between the ALU
//  writeback and the multi-cycle data-memory load return, and drives WRITE/INADDRESS/IN.
//  Keeps a load scoreboard: destination registers with a load in flight are busy.
//  Raises HAZARD so the CPU control unit stalls dependent reads.
// PARAMETERS
//  DATA_W     8   register data width
//  ADDR_W     3   register address width; NREGS = 2**ADDR_W = 8
//  MAX_LOADS  2   maximum outstanding loads (1..NREGS)
// PORTS
//  CLK            in   1       system clock; all state updates on posedge
//  RESET          in   1       synchronous, active-high reset
//  ALU_VALID      in   1       ALU result ready for writeback
//  ALU_ADDR       in   ADDR_W  ALU destination register
//  ALU_DATA       in   DATA_W  ALU result
//  ALU_READY      out  1       ALU writeback accepted this cycle (combinational)
//  LD_ISSUE       in   1       load issued to data memory this cycle
//  LD_ISSUE_ADDR  in   ADDR_W  destination register of the issued load
//  LD_VALID       in   1       load data returning; always accepted, no back-pressure
//  LD_ADDR        in   ADDR_W  destination of the returning load
//  LD_DATA        in   DATA_W  returning load data
//  RD1_ADDR       in   ADDR_W  register file OUT1ADDRESS, for hazard check
//  RD2_ADDR       in   ADDR_W  register file OUT2ADDRESS, for hazard check
//  HAZARD         out  1       stall request (combinational)
//  ISSUE_FULL     out  1       outstanding == MAX_LOADS; control unit must not issue
//  BUSY_MASK      out  NREGS   scoreboard bits, bit i = register i busy
//  ERR            out  1       sticky protocol-error flag
//  WRITE          out  1       register file write enable (registered)
//  INADDRESS      out  ADDR_W  register file write address (registered)
//  IN             out  DATA_W  register file write data (registered)
// BEHAVIOUR
//  - Reset: WRITE=0, INADDRESS=0, IN=0, BUSY_MASK=0, outstanding=0, ERR=0.
//    ALU_READY=0 and HAZARD=0 while RESET=1. LD_ISSUE and LD_VALID are ignored during reset.
//  - Grant: a load return has fixed priority over the ALU.
//    ALU_READY = !RESET & !LD_VALID & !BUSY_MASK[ALU_ADDR].
//    The busy term blocks a WAW overwrite by a younger ALU op.
//  - Latency: exactly 1 cycle. The winner is registered onto WRITE/INADDRESS/IN at the
//    next posedge, and the register file commits it on the posedge after that.
//    If there is no winner, WRITE=0 and INADDRESS/IN hold their last values.
//  - Scoreboard set: LD_ISSUE & !ISSUE_FULL & !busy[LD_ISSUE_ADDR] sets the busy bit and
//    increments outstanding. A violating issue is dropped and sets ERR.
//  - Scoreboard clear: LD_VALID clears busy[LD_ADDR] and decrements outstanding.
//    LD_VALID to a non-busy register is still written, sets ERR, and leaves the count unchanged.
//  - Simultaneous issue and return:
//    same address: the bit stays set, the count is unchanged, and no ERR is raised.
//    different addresses: set one bit and clear the other; the count is unchanged.
//    A return frees a slot for a same-cycle issue: the full check uses outstanding minus the return.
//  - Outstanding counter: width clog2(MAX_LOADS+1). It never wraps; over/underflow attempts set ERR.
//  - HAZARD = busy[RD1_ADDR] | busy[RD2_ADDR] | (WRITE & (INADDRESS==RD1_ADDR | INADDRESS==RD2_ADDR)).
//    The last term covers a write registered but not yet committed. There is no forwarding.
//  - ERR clears only on RESET.
//  - Reset mid-operation clears all state. Stale returns arriving after reset are written and flag ERR.
// STRUCTURE
//  - Shared header reg_arb_defs.vh: DATA_W, ADDR_W, NREGS, MAX_LOADS defaults.
//  - Sub-module load_scoreboard: busy bits, outstanding counter, ISSUE_FULL, ERR.
//  - Top level: grant logic, output register, HAZARD compare.
// TESTING
//  1. RESET for 2 cycles -> WRITE=0, INADDRESS=0, IN=0, BUSY_MASK=8'h00, ERR=0, HAZARD=0.
//  2. ALU_VALID, ADDR=3, DATA=8'h5A -> ALU_READY=1. Next cycle WRITE=1, INADDRESS=3, IN=5A;
//     reg3=5A after the following edge.
//  3. Conflict: LD_VALID (addr 2, 8'h11) and ALU_VALID (addr 4) in the same cycle
//     -> load written first, ALU_READY=0; the ALU is written next cycle.
//  4. LD_ISSUE addr 5, then RD1_ADDR=5 -> HAZARD=1 until the return cycle plus one.
//     BUSY_MASK=8'h20 while in flight. An ALU write to 5 is blocked meanwhile.
//  5. Issue loads to 1 and 6 -> ISSUE_FULL=1. A third issue to 7 is dropped, sets ERR=1,
//     and BUSY_MASK stays 8'h42.
//  6. Load to 0 in flight; assert RESET -> BUSY_MASK=0. Return to 0 after reset
//     -> written, ERR=1.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared widths and types for the register-file write arbiter.
// Defaults: 8-bit data, 8 registers, up to 2 loads in flight.
package reg_write_arbiter_pkg;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 3;
    localparam int NREGS     = 1 << ADDR_W;
    localparam int MAX_LOADS = 2;
    localparam int CNT_W     = $clog2(MAX_LOADS + 1);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [NREGS-1:0]  mask_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef struct packed {
        logic  write;
        addr_t addr;
        data_t data;
    } wr_req_t;
endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bundle of ALU writeback, load issue/return, hazard and register-file write signals.
// slave = arbiter side, master = CPU/control side.
interface reg_write_arbiter_if;
    import reg_write_arbiter_pkg::*;

    logic  ALU_VALID;
    addr_t ALU_ADDR;
    data_t ALU_DATA;
    logic  ALU_READY;
    logic  LD_ISSUE;
    addr_t LD_ISSUE_ADDR;
    logic  LD_VALID;
    addr_t LD_ADDR;
    data_t LD_DATA;
    addr_t RD1_ADDR;
    addr_t RD2_ADDR;
    logic  HAZARD;
    logic  ISSUE_FULL;
    mask_t BUSY_MASK;
    logic  ERR;
    logic  WRITE;
    addr_t INADDRESS;
    data_t IN;

    modport slave (
        input  ALU_VALID, ALU_ADDR, ALU_DATA, LD_ISSUE, LD_ISSUE_ADDR,
               LD_VALID, LD_ADDR, LD_DATA, RD1_ADDR, RD2_ADDR,
        output ALU_READY, HAZARD, ISSUE_FULL, BUSY_MASK, ERR, WRITE, INADDRESS, IN
    );

    modport master (
        output ALU_VALID, ALU_ADDR, ALU_DATA, LD_ISSUE, LD_ISSUE_ADDR,
               LD_VALID, LD_ADDR, LD_DATA, RD1_ADDR, RD2_ADDR,
        input  ALU_READY, HAZARD, ISSUE_FULL, BUSY_MASK, ERR, WRITE, INADDRESS, IN
    );
endinterface

// File: rtl/reg_write_arbiter_scoreboard.sv
// Load scoreboard: per-register busy bits, outstanding-load counter, sticky error.
// A same-cycle return is applied before the issue check so it frees its slot and bit.
module load_scoreboard
    import reg_write_arbiter_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  ld_issue,
    input  addr_t ld_issue_addr,
    input  logic  ld_valid,
    input  addr_t ld_addr,
    output mask_t busy_mask,
    output logic  issue_full,
    output logic  err
);
    mask_t busy_q, busy_d, busy_ret;
    cnt_t  cnt_q, cnt_d, cnt_ret;
    logic  err_q, err_d;
    logic  ret_hit, ret_miss, issue_ok;

    always_comb begin
        ret_hit  = ld_valid & busy_q[ld_addr];
        ret_miss = ld_valid & ~busy_q[ld_addr];
        busy_ret = busy_q;
        if (ret_hit) busy_ret[ld_addr] = 1'b0;
        cnt_ret  = cnt_q - cnt_t'(ret_hit);
        // Full and WAW checks see the post-return state.
        issue_ok = ld_issue & (cnt_ret != cnt_t'(MAX_LOADS)) & ~busy_ret[ld_issue_addr];
        busy_d   = busy_ret;
        if (issue_ok) busy_d[ld_issue_addr] = 1'b1;
        cnt_d    = cnt_ret + cnt_t'(issue_ok);
        err_d    = err_q | ret_miss | (ld_issue & ~issue_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign busy_mask  = busy_q;
    assign issue_full = (cnt_q == cnt_t'(MAX_LOADS));
    assign err        = err_q;
endmodule

// File: rtl/reg_write_arbiter.sv
// Owns the register-file write port: load returns beat ALU writebacks, one-cycle
// registered write, and a stall signal covering in-flight loads and uncommitted writes.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    reg_write_arbiter_if.slave bus
);
    wr_req_t wr_q, wr_d;
    mask_t   busy;
    logic    alu_ready;
    logic    pend_hit;

    load_scoreboard u_sb (
        .clk           (CLK),
        .rst           (RESET),
        .ld_issue      (bus.LD_ISSUE),
        .ld_issue_addr (bus.LD_ISSUE_ADDR),
        .ld_valid      (bus.LD_VALID),
        .ld_addr       (bus.LD_ADDR),
        .busy_mask     (busy),
        .issue_full    (bus.ISSUE_FULL),
        .err           (bus.ERR)
    );

    // The busy term stops a younger ALU op overwriting a register a load still owns.
    assign alu_ready = !RESET && !bus.LD_VALID && !busy[bus.ALU_ADDR];

    always_comb begin
        wr_d       = wr_q;
        wr_d.write = 1'b0;
        if (bus.LD_VALID) begin
            wr_d = '{write: 1'b1, addr: bus.LD_ADDR, data: bus.LD_DATA};
        end else if (bus.ALU_VALID && alu_ready) begin
            wr_d = '{write: 1'b1, addr: bus.ALU_ADDR, data: bus.ALU_DATA};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) wr_q <= '0;
        else       wr_q <= wr_d;
    end

    // A registered write lands in the file one edge later, so readers must still wait.
    assign pend_hit = wr_q.write && ((wr_q.addr == bus.RD1_ADDR) || (wr_q.addr == bus.RD2_ADDR));

    assign bus.HAZARD    = !RESET && (busy[bus.RD1_ADDR] || busy[bus.RD2_ADDR] || pend_hit);
    assign bus.ALU_READY = alu_ready;
    assign bus.BUSY_MASK = busy;
    assign bus.WRITE     = wr_q.write;
    assign bus.INADDRESS = wr_q.addr;
    assign bus.IN        = wr_q.data;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed scenarios plus a randomized run checked against a rule-level model.
module tb_reg_write_arbiter;
    import reg_write_arbiter_pkg::*;

    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   failures = 0;
    logic [DATA_W-1:0] rf [NREGS];

    reg_write_arbiter_if bus();

    reg_write_arbiter dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (bus.WRITE) rf[bus.INADDRESS] <= bus.IN;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.ALU_VALID = 0; bus.ALU_ADDR = 0; bus.ALU_DATA = 0;
        bus.LD_ISSUE = 0; bus.LD_ISSUE_ADDR = 0;
        bus.LD_VALID = 0; bus.LD_ADDR = 0; bus.LD_DATA = 0;
        bus.RD1_ADDR = 0; bus.RD2_ADDR = 0;
    endtask

    task automatic test_reset();
        idle();
        RESET = 1;
        bus.LD_VALID = 1; bus.LD_ADDR = 3; bus.ALU_VALID = 1; bus.ALU_ADDR = 1;
        tick(); tick();
        checks++; if ({bus.WRITE, bus.INADDRESS, bus.IN} !== 12'h000) begin
            failures++; $display("FAIL reset_wr got=%h exp=000", {bus.WRITE, bus.INADDRESS, bus.IN});
        end
        checks++; if (bus.BUSY_MASK !== 8'h00 || bus.ERR !== 1'b0) begin
            failures++; $display("FAIL reset_sb got busy=%h err=%b exp busy=00 err=0", bus.BUSY_MASK, bus.ERR);
        end
        checks++; if (bus.HAZARD !== 1'b0 || bus.ALU_READY !== 1'b0) begin
            failures++; $display("FAIL reset_comb got hz=%b rdy=%b exp 0 0", bus.HAZARD, bus.ALU_READY);
        end
        idle();
        RESET = 0;
        tick();
    endtask

    task automatic test_alu_write();
        bus.ALU_VALID = 1; bus.ALU_ADDR = 3; bus.ALU_DATA = 8'h5A;
        #1;
        checks++; if (bus.ALU_READY !== 1'b1) begin
            failures++; $display("FAIL alu_ready got=%b exp=1", bus.ALU_READY);
        end
        tick();
        bus.ALU_VALID = 0;
        checks++; if ({bus.WRITE, bus.INADDRESS, bus.IN} !== {1'b1, 3'd3, 8'h5A}) begin
            failures++; $display("FAIL alu_wr got=%h exp=%h", {bus.WRITE, bus.INADDRESS, bus.IN}, {1'b1, 3'd3, 8'h5A});
        end
        tick();
        checks++; if (rf[3] !== 8'h5A || bus.WRITE !== 1'b0 || bus.INADDRESS !== 3'd3 || bus.IN !== 8'h5A) begin
            failures++; $display("FAIL alu_commit got rf3=%h wr=%b a=%0d in=%h exp 5a 0 3 5a", rf[3], bus.WRITE, bus.INADDRESS, bus.IN);
        end
    endtask

    task automatic test_conflict();
        bus.LD_ISSUE = 1; bus.LD_ISSUE_ADDR = 2;
        tick();
        bus.LD_ISSUE = 0;
        bus.LD_VALID = 1; bus.LD_ADDR = 2; bus.LD_DATA = 8'h11;
        bus.ALU_VALID = 1; bus.ALU_ADDR = 4; bus.ALU_DATA = 8'h77;
        #1;
        checks++; if (bus.ALU_READY !== 1'b0) begin
            failures++; $display("FAIL conflict_rdy got=%b exp=0", bus.ALU_READY);
        end
        tick();
        bus.LD_VALID = 0;
        #1;
        checks++; if ({bus.WRITE, bus.INADDRESS, bus.IN, bus.ALU_READY} !== {1'b1, 3'd2, 8'h11, 1'b1}) begin
            failures++; $display("FAIL conflict_ld got=%h exp=%h", {bus.WRITE, bus.INADDRESS, bus.IN, bus.ALU_READY}, {1'b1, 3'd2, 8'h11, 1'b1});
        end
        tick();
        bus.ALU_VALID = 0;
        checks++; if ({bus.WRITE, bus.INADDRESS, bus.IN, bus.ERR, bus.BUSY_MASK} !== {1'b1, 3'd4, 8'h77, 1'b0, 8'h00}) begin
            failures++; $display("FAIL conflict_alu got=%h exp=%h", {bus.WRITE, bus.INADDRESS, bus.IN, bus.ERR, bus.BUSY_MASK}, {1'b1, 3'd4, 8'h77, 1'b0, 8'h00});
        end
        tick();
    endtask

    task automatic test_load_hazard();
        bus.LD_ISSUE = 1; bus.LD_ISSUE_ADDR = 5;
        tick();
        bus.LD_ISSUE = 0; bus.RD1_ADDR = 5; bus.RD2_ADDR = 1;
        bus.ALU_VALID = 1; bus.ALU_ADDR = 5; bus.ALU_DATA = 8'h99;
        #1;
        checks++; if (bus.BUSY_MASK !== 8'h20 || bus.HAZARD !== 1'b1 || bus.ALU_READY !== 1'b0) begin
            failures++; $display("FAIL hz_inflight got busy=%h hz=%b rdy=%b exp 20 1 0", bus.BUSY_MASK, bus.HAZARD, bus.ALU_READY);
        end
        tick();
        bus.ALU_VALID = 0;
        bus.LD_VALID = 1; bus.LD_ADDR = 5; bus.LD_DATA = 8'h33;
        #1;
        checks++; if (bus.WRITE !== 1'b0 || bus.HAZARD !== 1'b1) begin
            failures++; $display("FAIL hz_blocked got wr=%b hz=%b exp 0 1", bus.WRITE, bus.HAZARD);
        end
        tick();
        bus.LD_VALID = 0;
        #1;
        checks++; if ({bus.WRITE, bus.INADDRESS, bus.IN, bus.HAZARD, bus.BUSY_MASK} !== {1'b1, 3'd5, 8'h33, 1'b1, 8'h00}) begin
            failures++; $display("FAIL hz_return got=%h exp=%h", {bus.WRITE, bus.INADDRESS, bus.IN, bus.HAZARD, bus.BUSY_MASK}, {1'b1, 3'd5, 8'h33, 1'b1, 8'h00});
        end
        tick();
        checks++; if (bus.HAZARD !== 1'b0 || rf[5] !== 8'h33) begin
            failures++; $display("FAIL hz_clear got hz=%b rf5=%h exp 0 33", bus.HAZARD, rf[5]);
        end
        idle();
    endtask

    task automatic test_issue_full();
        bus.LD_ISSUE = 1; bus.LD_ISSUE_ADDR = 1; tick();
        bus.LD_ISSUE_ADDR = 6; tick();
        checks++; if (bus.ISSUE_FULL !== 1'b1 || bus.BUSY_MASK !== 8'h42 || bus.ERR !== 1'b0) begin
            failures++; $display("FAIL full_set got full=%b busy=%h err=%b exp 1 42 0", bus.ISSUE_FULL, bus.BUSY_MASK, bus.ERR);
        end
        bus.LD_ISSUE_ADDR = 7; tick();
        checks++; if (bus.ISSUE_FULL !== 1'b1 || bus.BUSY_MASK !== 8'h42 || bus.ERR !== 1'b1) begin
            failures++; $display("FAIL full_drop got full=%b busy=%h err=%b exp 1 42 1", bus.ISSUE_FULL, bus.BUSY_MASK, bus.ERR);
        end
        // Return to 1 frees a slot for the same-cycle issue to 7.
        bus.LD_VALID = 1; bus.LD_ADDR = 1; bus.LD_DATA = 8'hC1;
        tick();
        bus.LD_ISSUE = 0;
        checks++; if (bus.ISSUE_FULL !== 1'b1 || bus.BUSY_MASK !== 8'hC0) begin
            failures++; $display("FAIL full_swap got full=%b busy=%h exp 1 c0", bus.ISSUE_FULL, bus.BUSY_MASK);
        end
        bus.LD_ADDR = 6; tick();
        bus.LD_ADDR = 7; tick();
        bus.LD_VALID = 0;
        checks++; if (bus.ISSUE_FULL !== 1'b0 || bus.BUSY_MASK !== 8'h00) begin
            failures++; $display("FAIL full_drain got full=%b busy=%h exp 0 00", bus.ISSUE_FULL, bus.BUSY_MASK);
        end
        idle();
    endtask

    task automatic test_reset_midflight();
        RESET = 1; tick(); RESET = 0;
        bus.LD_ISSUE = 1; bus.LD_ISSUE_ADDR = 0; tick();
        bus.LD_ISSUE = 0;
        checks++; if (bus.BUSY_MASK !== 8'h01 || bus.ERR !== 1'b0) begin
            failures++; $display("FAIL mid_issue got busy=%h err=%b exp 01 0", bus.BUSY_MASK, bus.ERR);
        end
        RESET = 1; tick(); RESET = 0;
        checks++; if (bus.BUSY_MASK !== 8'h00 || bus.ISSUE_FULL !== 1'b0 || bus.ERR !== 1'b0) begin
            failures++; $display("FAIL mid_reset got busy=%h full=%b err=%b exp 00 0 0", bus.BUSY_MASK, bus.ISSUE_FULL, bus.ERR);
        end
        bus.LD_VALID = 1; bus.LD_ADDR = 0; bus.LD_DATA = 8'hAB; tick();
        bus.LD_VALID = 0;
        checks++; if ({bus.WRITE, bus.INADDRESS, bus.IN, bus.ERR} !== {1'b1, 3'd0, 8'hAB, 1'b1}) begin
            failures++; $display("FAIL mid_stale got=%h exp=%h", {bus.WRITE, bus.INADDRESS, bus.IN, bus.ERR}, {1'b1, 3'd0, 8'hAB, 1'b1});
        end
        RESET = 1; tick(); RESET = 0;
    endtask

    task automatic test_random();
        logic [NREGS-1:0] mb;
        int mc;
        logic me, ew, m_rdy, m_hz;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic [24:0] got, exp;
        mb = 0; mc = 0; me = 0; ew = 0; ea = 0; ed = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            RESET = ($urandom_range(0, 59) == 0);
            bus.ALU_VALID = $urandom_range(0, 1);
            bus.ALU_ADDR = $urandom; bus.ALU_DATA = $urandom;
            bus.LD_ISSUE = ($urandom_range(0, 9) < 4);
            bus.LD_ISSUE_ADDR = $urandom;
            bus.LD_VALID = ($urandom_range(0, 9) < 3);
            bus.LD_ADDR = $urandom; bus.LD_DATA = $urandom;
            if (mb != 0 && $urandom_range(0, 9) != 0) begin
                while (!mb[bus.LD_ADDR]) bus.LD_ADDR = bus.LD_ADDR + 1'b1;
            end
            bus.RD1_ADDR = $urandom; bus.RD2_ADDR = $urandom;
            #1;
            m_rdy = !RESET && !bus.LD_VALID && !mb[bus.ALU_ADDR];
            m_hz = !RESET && (mb[bus.RD1_ADDR] || mb[bus.RD2_ADDR] ||
                   (ew && (ea == bus.RD1_ADDR || ea == bus.RD2_ADDR)));
            exp = {m_rdy, m_hz, (mc == MAX_LOADS), mb, me, ew, ea, ed};
            got = {bus.ALU_READY, bus.HAZARD, bus.ISSUE_FULL, bus.BUSY_MASK, bus.ERR, bus.WRITE, bus.INADDRESS, bus.IN};
            checks++; if (got !== exp) begin
                failures++; $display("FAIL random_cycle%0d got=%h exp=%h", cyc, got, exp);
            end
            if (RESET) begin
                mb = 0; mc = 0; me = 0; ew = 0; ea = 0; ed = 0;
            end else begin
                ew = 0;
                if (bus.LD_VALID) begin ew = 1; ea = bus.LD_ADDR; ed = bus.LD_DATA; end
                else if (bus.ALU_VALID && m_rdy) begin ew = 1; ea = bus.ALU_ADDR; ed = bus.ALU_DATA; end
                if (bus.LD_VALID) begin
                    if (mb[bus.LD_ADDR]) begin mb[bus.LD_ADDR] = 0; mc--; end
                    else me = 1;
                end
                if (bus.LD_ISSUE) begin
                    if (mc == MAX_LOADS || mb[bus.LD_ISSUE_ADDR]) me = 1;
                    else begin mb[bus.LD_ISSUE_ADDR] = 1; mc++; end
                end
            end
            tick();
        end
        RESET = 0;
        idle();
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_conflict();
        test_load_hazard();
        test_issue_full();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
